// File: rtl/rle_pkg.sv
// Shared RLE definitions: field widths, run word layout and decoder states.
// Used by the run-length encoder and decoder.
package rle_pkg;

  localparam int RLE_CNT_W  = 23;
  localparam int RLE_BYTE_W = 8;

  typedef struct packed {
    logic                 bit_id;
    logic [RLE_CNT_W-1:0] run_len;
  } rle_word_t;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_REQUEST,
    ST_WAIT_IN,
    ST_LOAD,
    ST_EXPAND,
    ST_PUT,
    ST_WAIT_OUT,
    ST_FLUSH,
    ST_DONE
  } rle_dec_state_e;

endpackage

// File: rtl/rle_dec_packer.sv
// LSB-first bit accumulator: appends one bit per valid cycle at the
// current fill position until BYTE_W bits are held.
module rle_dec_packer
  import rle_pkg::*;
#(
  parameter int BYTE_W = RLE_BYTE_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        bit_i,
  input  logic                        valid_i,
  input  logic                        clear_i,
  output logic [BYTE_W-1:0]           byte_o,
  output logic [$clog2(BYTE_W+1)-1:0] fill_o,
  output logic                        full_o
);

  localparam int FILL_W = $clog2(BYTE_W + 1);

  logic [BYTE_W-1:0] buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;

  assign full_o = (fill_q == FILL_W'(BYTE_W));
  assign byte_o = buf_q;
  assign fill_o = fill_q;

  // Next buffer: clear wins, otherwise drop the bit into slot fill.
  always_comb begin
    buf_d  = buf_q;
    fill_d = fill_q;
    if (clear_i) begin
      buf_d  = '0;
      fill_d = '0;
    end else if (valid_i && !full_o) begin
      buf_d  = buf_q | (BYTE_W'(bit_i) << fill_q);
      fill_d = fill_q + FILL_W'(1);
    end
  end

  // Buffer and fill count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q  <= '0;
      fill_q <= '0;
    end else begin
      buf_q  <= buf_d;
      fill_q <= fill_d;
    end
  end

endmodule

// File: rtl/rle_dec.sv
// Run-length decoder: expands {bit_id, run_len} words into LSB-first bytes.
// Define RLE_DEC_FLUSH_EN to emit a trailing partial byte at end of stream.
module rle_dec
  import rle_pkg::*;
#(
  parameter int CNT_W  = RLE_CNT_W,
  parameter int BYTE_W = RLE_BYTE_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              recv_ready,
  output logic              rd_req,
  input  logic [CNT_W:0]    in_data,
  input  logic              send_ready,
  output logic              wr_req,
  output logic [BYTE_W-1:0] out_data,
  input  logic              end_of_stream,
  output logic              done
);

  localparam int FILL_W = $clog2(BYTE_W + 1);

  rle_dec_state_e    state_q;
  logic              value_q;
  logic [CNT_W-1:0]  remaining_q;
  logic              rd_req_q;
  logic              wr_req_q;
  logic [BYTE_W-1:0] out_data_q;
  logic              done_q;

  logic              pk_valid;
  logic              pk_clear;
  logic              flush_wr;
  logic [BYTE_W-1:0] pk_byte;
  logic [FILL_W-1:0] pk_fill;
  logic              pk_full;

  assign rd_req   = rd_req_q;
  assign wr_req   = wr_req_q;
  assign out_data = out_data_q;
  assign done     = done_q;

`ifdef RLE_DEC_FLUSH_EN
  assign flush_wr = (state_q == ST_FLUSH) && (pk_fill != '0)
                 && send_ready;
`else
  assign flush_wr = 1'b0;
`endif

  // Packer is fed during EXPAND and emptied after every byte write.
  always_comb begin
    pk_valid = (state_q == ST_EXPAND);
    pk_clear = (state_q == ST_INIT) || (state_q == ST_WAIT_OUT)
            || flush_wr;
  end

  rle_dec_packer #(
    .BYTE_W (BYTE_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .bit_i   (value_q),
    .valid_i (pk_valid),
    .clear_i (pk_clear),
    .byte_o  (pk_byte),
    .fill_o  (pk_fill),
    .full_o  (pk_full)
  );

  // Control FSM with registered FIFO handshakes and done flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      value_q     <= 1'b0;
      remaining_q <= '0;
      rd_req_q    <= 1'b0;
      wr_req_q    <= 1'b0;
      out_data_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        ST_INIT: begin
          value_q     <= 1'b0;
          remaining_q <= '0;
          state_q     <= ST_REQUEST;
        end
        ST_REQUEST: begin
          if (recv_ready) begin
            rd_req_q <= 1'b1;
            state_q  <= ST_WAIT_IN;
          end else if (end_of_stream) begin
            state_q <= ST_FLUSH;
          end
        end
        ST_WAIT_IN: begin
          rd_req_q <= 1'b0;
          state_q  <= ST_LOAD;
        end
        ST_LOAD: begin
          value_q     <= in_data[CNT_W];
          remaining_q <= in_data[CNT_W-1:0];
          if (in_data[CNT_W-1:0] == '0) state_q <= ST_REQUEST;
          else                          state_q <= ST_EXPAND;
        end
        ST_EXPAND: begin
          remaining_q <= remaining_q - CNT_W'(1);
          if (pk_fill == FILL_W'(BYTE_W - 1))
            state_q <= ST_PUT;
          else if (remaining_q == CNT_W'(1))
            state_q <= ST_REQUEST;
        end
        ST_PUT: begin
          if (send_ready && pk_full) begin
            out_data_q <= pk_byte;
            wr_req_q   <= 1'b1;
            state_q    <= ST_WAIT_OUT;
          end
        end
        ST_WAIT_OUT: begin
          wr_req_q <= 1'b0;
          if (remaining_q != '0) begin
            state_q <= ST_EXPAND;
          end else if (end_of_stream && !recv_ready) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_REQUEST;
          end
        end
        ST_FLUSH: begin
`ifdef RLE_DEC_FLUSH_EN
          if (pk_fill != '0) begin
            if (send_ready) begin
              out_data_q <= pk_byte;
              wr_req_q   <= 1'b1;
            end
          end else begin
            wr_req_q <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
`else
          done_q  <= 1'b1;
          state_q <= ST_DONE;
`endif
        end
        ST_DONE: begin
          if (!end_of_stream) begin
            done_q  <= 1'b0;
            state_q <= ST_INIT;
          end
        end
        default: state_q <= ST_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_rle_dec.sv
// Testbench for rle_dec: directed cases plus random sessions checked
// against a bit-queue reference model.
module tb_rle_dec;
  import rle_pkg::*;

`ifdef RLE_DEC_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             recv_ready;
  logic             rd_req;
  logic [RLE_CNT_W:0] in_data;
  logic             send_ready;
  logic             wr_req;
  logic [7:0]       out_data;
  logic             end_of_stream;
  logic             done;

  always #5 clk = ~clk;

  rle_dec dut (
    .clk           (clk),
    .rst           (rst),
    .recv_ready    (recv_ready),
    .rd_req        (rd_req),
    .in_data       (in_data),
    .send_ready    (send_ready),
    .wr_req        (wr_req),
    .out_data      (out_data),
    .end_of_stream (end_of_stream),
    .done          (done)
  );

  int         total = 0;
  int         bad = 0;
  rle_word_t  words[$];
  rle_word_t  pend[$];
  rle_word_t  fifo[$];
  logic [7:0] got[$];
  logic [7:0] exp_q[$];
  int         rd_cnt;
  logic       prev_wr;
  int         sr_mode;
  bit         feed_rand;

  task automatic chk(input string tag, input logic [31:0] act,
                     input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, req);
    end
  endtask

  function automatic rle_word_t mk(input bit b, input int l);
    rle_word_t w;
    w.bit_id  = b;
    w.run_len = RLE_CNT_W'(l);
    return w;
  endfunction

  // One clock: monitor outputs, serve the input FIFO, drive send_ready.
  task automatic tick();
    @(negedge clk);
    if (wr_req) begin
      chk("wr_pulse", 32'(prev_wr), 0);
      got.push_back(out_data);
    end
    prev_wr = wr_req;
    if (rd_req) begin
      chk("rd_nonempty", 32'(fifo.size() > 0), 1);
      rd_cnt++;
      if (fifo.size() > 0) in_data = fifo.pop_front();
    end
    if (pend.size() > 0 && (!feed_rand || $urandom_range(0, 3) == 0))
      fifo.push_back(pend.pop_front());
    recv_ready = (fifo.size() > 0);
    case (sr_mode)
      0:       send_ready = 1'b0;
      1:       send_ready = 1'b1;
      default: send_ready = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Reference: concatenate all run bits, cut into LSB-first bytes.
  task automatic build_exp();
    bit         bits[$];
    logic [7:0] b;
    int         n;
    exp_q.delete();
    foreach (words[i])
      for (int k = 0; k < int'(words[i].run_len); k++)
        bits.push_back(words[i].bit_id);
    while (bits.size() >= 8) begin
      for (int k = 0; k < 8; k++) b[k] = bits.pop_front();
      exp_q.push_back(b);
    end
    n = bits.size();
    if (FLUSH_EN && n > 0) begin
      b = '0;
      for (int k = 0; k < n; k++) b[k] = bits[k];
      exp_q.push_back(b);
    end
  endtask

  task automatic begin_session();
    got.delete();
    rd_cnt = 0;
  endtask

  task automatic finish_session(input string tag);
    int n;
    end_of_stream = 1'b1;
    n = 0;
    while (!done && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 1);
    build_exp();
    chk({tag, "_nbytes"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
    chk({tag, "_nreads"}, rd_cnt, words.size());
    end_of_stream = 1'b0;
    tick();
    tick();
    chk({tag, "_done_clr"}, 32'(done), 0);
  endtask

  task automatic run_session(input string tag);
    int n;
    begin_session();
    foreach (words[i]) pend.push_back(words[i]);
    n = 0;
    while (pend.size() > 0 && n < 4000) begin
      tick();
      n++;
    end
    chk({tag, "_feed"}, pend.size(), 0);
    finish_session(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    pend.delete();
    fifo.delete();
    recv_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int nw;
    rst           = 1'b1;
    end_of_stream = 1'b0;
    recv_ready    = 1'b0;
    send_ready    = 1'b1;
    in_data       = '0;
    sr_mode       = 1;
    feed_rand     = 1'b0;
    prev_wr       = 1'b0;
    rd_cnt        = 0;
    tick();
    tick();
    tick();
    chk("rst_rd", 32'(rd_req), 0);
    chk("rst_wr", 32'(wr_req), 0);
    chk("rst_out", 32'(out_data), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;

    words.delete();
    words.push_back(mk(0, 4));
    words.push_back(mk(1, 4));
    run_session("f0");

    words.delete();
    words.push_back(mk(1, 3));
    words.push_back(mk(0, 5));
    words.push_back(mk(1, 16));
    run_session("cross");

    words.delete();
    words.push_back(mk(1, 0));
    words.push_back(mk(0, 8));
    run_session("zero");

    // Latency: wr_req 12 cycles after REQUEST is entered.
    do_reset();
    begin_session();
    words.delete();
    words.push_back(mk(1, 8));
    fifo.push_back(words[0]);
    recv_ready = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wr_req && n < 50);
    chk("lat", n, 13);
    finish_session("lat");

    // Output FIFO full: byte must wait in PUT.
    do_reset();
    begin_session();
    fifo.push_back(words[0]);
    recv_ready = 1'b1;
    sr_mode    = 0;
    send_ready = 1'b0;
    repeat (20) tick();
    chk("stall_nowr", got.size(), 0);
    chk("stall_wr", 32'(wr_req), 0);
    sr_mode    = 1;
    send_ready = 1'b1;
    tick();
    chk("put_wr", 32'(wr_req), 1);
    chk("put_data", 32'(out_data), 32'hFF);
    finish_session("stall");

    words.delete();
    words.push_back(mk(1, 3));
    run_session("flush");

    // Reset while the 5th bit of {1,8} is being expanded.
    do_reset();
    begin_session();
    words.delete();
    words.push_back(mk(1, 8));
    fifo.push_back(words[0]);
    recv_ready = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    chk("mid_rd", 32'(rd_req), 0);
    chk("mid_wr", 32'(wr_req), 0);
    chk("mid_out", 32'(out_data), 0);
    fifo.delete();
    tick();
    rst = 1'b0;
    words.delete();
    words.push_back(mk(0, 8));
    run_session("after_rst");

    feed_rand = 1'b1;
    sr_mode   = 2;
    for (int s = 0; s < 40; s++) begin
      words.delete();
      nw = $urandom_range(1, 6);
      for (int i = 0; i < nw; i++) begin
        if ($urandom_range(0, 7) == 0)
          words.push_back(mk($urandom_range(0, 1), 0));
        else
          words.push_back(mk($urandom_range(0, 1),
                             $urandom_range(1, 24)));
      end
      run_session($sformatf("rnd%0d", s));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rle_dec.md
# rle_dec

Run-length decoder, the inverse of the team's RLE encoder. It pops 24-bit run words `{bit_id, run_length[22:0]}` from an input-side FIFO and expands each run into individual bits. It packs those bits LSB-first into bytes and pushes each completed byte to an output-side FIFO. It sits between the compressed-stream FIFO and the reconstructed-image FIFO and uses the same one-cycle rd_req/wr_req FIFO handshakes.

## Interface
- CNT_W, 23, run-length field width; the input word is CNT_W+1 bits.
- BYTE_W, 8, output word width; bits are packed LSB-first.
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset rst, synchronous, active-high; clock clk.
- recv_ready  in  1  input FIFO not empty.
- rd_req  out  1  input FIFO read request; asserted for exactly one cycle per word.
- in_data  in  CNT_W+1  run word: [CNT_W] is bit ID, [CNT_W-1:0] is run length; valid two cycles after rd_req is asserted.
- send_ready  in  1  output FIFO not full.
- wr_req  out  1  output FIFO write request; asserted for exactly one cycle per byte.
- out_data  out  BYTE_W  packed byte; stable from the wr_req cycle until the next byte is packed.
- end_of_stream  in  1  no further run words will arrive once the input FIFO is empty.
- done  out  1  high while in DONE.

## Operation
- Registers:
  - value: bit ID of the current run.
  - remaining: CNT_W-bit count of bits still to emit.
  - byte_buf: BYTE_W-bit packing buffer.
  - fill: 0..BYTE_W, number of bits currently in byte_buf.
- Reset values: all of the above are 0; state is INIT; rd_req=0, wr_req=0, out_data=0, done=0.
- INIT: clear registers -> REQUEST.
- REQUEST:
  - recv_ready=1: rd_req<=1 -> WAIT_IN.
  - Otherwise, if end_of_stream=1 -> FLUSH.
  - Otherwise stay in REQUEST.
  - recv_ready has priority over end_of_stream.
- WAIT_IN: rd_req<=0 -> LOAD.
- LOAD:
  - value<=in_data[CNT_W]; remaining<=in_data[CNT_W-1:0].
  - Length 0: the word is discarded -> REQUEST.
  - Otherwise -> EXPAND.
- EXPAND (one bit per cycle):
  - byte_buf[fill]<=value; fill<=fill+1; remaining<=remaining-1.
  - If the new fill equals BYTE_W -> PUT.
  - Else if the new remaining is 0 -> REQUEST.
  - Else stay in EXPAND.
- PUT:
  - send_ready=1: out_data<=byte_buf; wr_req<=1 -> WAIT_OUT.
  - Otherwise stall in PUT; no bits are lost.
- WAIT_OUT:
  - wr_req<=0; fill<=0; byte_buf<=0.
  - remaining!=0 -> EXPAND.
  - Else if end_of_stream=1 and recv_ready=0 -> DONE.
  - Else -> REQUEST.
- FLUSH: behaviour per Configuration. Ends in DONE.
- DONE: done=1. Leaves for INIT when end_of_stream falls.
- Runs cross byte boundaries freely. A run of 2^CNT_W-1 bits needs no special handling, and remaining never underflows.

## Timing
- Run word fetch: REQUEST -> WAIT_IN -> LOAD takes 3 cycles. rd_req is high only during the cycle after REQUEST is entered with recv_ready=1.
- Expansion costs 1 cycle per bit.
- Each byte write costs 2 cycles (PUT, WAIT_OUT) when send_ready=1.
- Example: word {1, 8} with recv_ready already high gives wr_req 3+8+1 = 12 cycles after entering REQUEST.
- recv_ready is ignored outside REQUEST. send_ready is ignored outside PUT.
- Reset mid-run discards the partial byte and remaining bits. Outputs are 0 in the cycle after rst is sampled high.

## Configuration
- Macro: RLE_DEC_FLUSH_EN.
- Defined: FLUSH with fill>0 behaves as PUT, writing byte_buf with unfilled upper bits 0, then goes to DONE. With fill=0, FLUSH goes directly to DONE.
- Undefined: a partial byte is silently dropped, and FLUSH goes directly to DONE. Only whole bytes are ever written.

## Structure
- Package rle_pkg holds:
  - RLE_CNT_W=23 and RLE_BYTE_W=8, shared with the encoder.
  - The run-word typedef (struct: bit_id, run_len).
  - The decoder state enum.
- One natural sub-module, rle_dec_packer: LSB-first bit accumulator with inputs bit/valid/clear and outputs byte/full. The FSM stays in rle_dec.

## Test plan
- Words {0,4},{1,4} -> one write of 0xF0; no further writes.
- Words {1,3},{0,5} -> 0x07. Then word {1,16} -> 0xFF, 0xFF; three writes total.
- Words {1,0},{0,8} -> the zero-length word is consumed with no bit emitted; single write of 0x00.
- Word {1,8} with send_ready held low 20 cycles -> stays in PUT with wr_req=0. wr_req pulses once, out_data=0xFF, the cycle after send_ready rises.
- Word {1,3} then end_of_stream=1 with FIFO empty:
  - With RLE_DEC_FLUSH_EN: write 0x07, then done=1.
  - Without: no write, done=1.
- rst during the 5th bit of {1,8} -> next cycle rd_req=wr_req=0 and out_data=0. Following word {0,8} yields exactly 0x00.
